// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: NS/EW six-phase light sequencer timed by an internal tick prescaler, with pedestrian green cut.
// Define TLC_FLASH_EN to flash both directions yellow while en=0 instead of freezing everything.
module traffic_light_ctrl #(
   parameter int DIV_RATIO = 50000000,
   parameter int GREEN_T   = 10,
   parameter int YELLOW_T  = 3,
   parameter int ALLRED_T  = 1,
   parameter int PED_MIN   = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       ped_req,
   output logic       ped_ack,
   output logic       tick,
   output logic [2:0] light_ns,
   output logic [2:0] light_ew,
   output logic [2:0] phase,
   output logic [7:0] remain
);
   localparam int CW = $clog2(DIV_RATIO);
   localparam logic [CW-1:0] CNT_MAX = CW'(DIV_RATIO - 1);
   localparam logic [2:0] NS_GREEN  = 3'd0;
   localparam logic [2:0] NS_YELLOW = 3'd1;
   localparam logic [2:0] ALL_RED_A = 3'd2;
   localparam logic [2:0] EW_GREEN  = 3'd3;
   localparam logic [2:0] EW_YELLOW = 3'd4;
   localparam logic [2:0] ALL_RED_B = 3'd5;

   logic [CW-1:0] cnt;
   logic          run, step, pending, serve, is_green;
   logic [2:0]    nxt_phase;
   logic [7:0]    nxt_remain;

   function automatic logic [5:0] lights_of(input logic [2:0] p);
      return p == NS_GREEN  ? 6'b001_100 :
             p == NS_YELLOW ? 6'b010_100 :
             p == EW_GREEN  ? 6'b100_001 :
             p == EW_YELLOW ? 6'b100_010 : 6'b100_100;
   endfunction

   function automatic logic [7:0] dur_of(input logic [2:0] p);
      return (p == NS_GREEN  || p == EW_GREEN)  ? 8'(GREEN_T - 1)  :
             (p == NS_YELLOW || p == EW_YELLOW) ? 8'(YELLOW_T - 1) : 8'(ALLRED_T - 1);
   endfunction

   assign tick     = run && cnt == CNT_MAX;
   assign step     = tick && en;
   assign is_green = phase == NS_GREEN || phase == EW_GREEN;
   assign serve    = step && pending && remain == 8'd0 && (phase == NS_YELLOW || phase == EW_YELLOW);

   always_comb begin
      nxt_phase  = phase;
      nxt_remain = remain;
      if (step) begin
         if (is_green && pending && remain > 8'(PED_MIN - 1))
            nxt_remain = 8'(PED_MIN - 1);
         else if (remain != 8'd0)
            nxt_remain = remain - 8'd1;
         else begin
            nxt_phase  = phase == ALL_RED_B ? NS_GREEN : phase + 3'd1;
            nxt_remain = dur_of(nxt_phase);
         end
      end
   end

   // pending clears at the end of the ack cycle; a request arriving in that cycle is deliberately dropped
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt     <= '0;
         phase   <= NS_GREEN;
         remain  <= 8'(GREEN_T - 1);
         pending <= 1'b0;
         ped_ack <= 1'b0;
      end else begin
         if (run)
            cnt <= cnt == CNT_MAX ? '0 : cnt + 1'b1;
         phase   <= nxt_phase;
         remain  <= nxt_remain;
         ped_ack <= serve;
         pending <= ped_ack ? 1'b0 : (pending | ped_req);
      end
   end

`ifdef TLC_FLASH_EN
   logic flash_off;
   assign run = 1'b1;
   always_ff @(posedge clk) begin
      if (!rst) begin
         flash_off              <= 1'b0;
         {light_ns, light_ew}   <= 6'b001_100;
      end else if (en) begin
         flash_off              <= 1'b0;
         {light_ns, light_ew}   <= lights_of(nxt_phase);
      end else if (tick) begin
         flash_off              <= ~flash_off;
         {light_ns, light_ew}   <= flash_off ? 6'b000_000 : 6'b010_010;
      end
   end
`else
   assign run = en;
   always_ff @(posedge clk) begin
      if (!rst)
         {light_ns, light_ew} <= 6'b001_100;
      else
         {light_ns, light_ew} <= lights_of(nxt_phase);
   end
`endif
endmodule

// File: tb/tb_traffic_light_ctrl.sv
// tb_traffic_light_ctrl: directed checks of sequencing, pedestrian cut/serve, freeze and reset.
module tb_traffic_light_ctrl;
   logic       clk = 1'b0, rst = 1'b0, en = 1'b1, ped_req = 1'b0;
   logic       ped_ack, tick;
   logic [2:0] light_ns, light_ew, phase;
   logic [7:0] remain;
   int         checks = 0, errors = 0, k = 0;

   always #5 clk = ~clk;

   traffic_light_ctrl #(.DIV_RATIO(4), .GREEN_T(5), .YELLOW_T(2), .ALLRED_T(1), .PED_MIN(2)) dut (
      .clk(clk), .rst(rst), .en(en), .ped_req(ped_req), .ped_ack(ped_ack), .tick(tick),
      .light_ns(light_ns), .light_ew(light_ew), .phase(phase), .remain(remain)
   );

   // k counts rising edges since the last reset edge; sampling and driving happen on falling edges
   task automatic cyc(input int n);
      repeat (n) begin
         @(negedge clk);
         k++;
      end
   endtask

   task automatic go_to(input int t);
      while (k < t) cyc(1);
   endtask

   task automatic do_reset;
      rst = 1'b0; en = 1'b1; ped_req = 1'b0;
      cyc(1);
      rst = 1'b1; k = 0;
   endtask

   task automatic pulse_req;
      ped_req = 1'b1;
      cyc(1);
      ped_req = 1'b0;
   endtask

   task automatic test_reset;
      do_reset;
      checks++;
      if ({phase, remain, light_ns, light_ew, tick, ped_ack} !== {3'd0, 8'd4, 6'b001_100, 2'b00}) begin
         errors++;
         $display("FAIL reset_state got ph=%0d rem=%0d ns=%b ew=%b tick=%b ack=%b exp ph=0 rem=4 ns=001 ew=100 tick=0 ack=0",
                  phase, remain, light_ns, light_ew, tick, ped_ack);
      end
      rst = 1'b0; ped_req = 1'b1;
      cyc(6);
      checks++;
      if ({phase, remain, light_ns, light_ew, tick, ped_ack} !== {3'd0, 8'd4, 6'b001_100, 2'b00}) begin
         errors++;
         $display("FAIL reset_priority got ph=%0d rem=%0d tick=%b ack=%b exp ph=0 rem=4 tick=0 ack=0", phase, remain, tick, ped_ack);
      end
      ped_req = 1'b0;
      cyc(1);
      rst = 1'b1; k = 0;
      go_to(4);
      checks++;
      if (remain !== 8'd3) begin
         errors++;
         $display("FAIL reset_clears_pending got rem=%0d exp 3", remain);
      end
   endtask

   task automatic test_run;
      int         ks [7];
      logic [16:0] ex [7];
      ks = '{19, 20, 28, 32, 52, 60, 64};
      ex = '{{3'd0, 8'd0, 6'b001_100}, {3'd1, 8'd1, 6'b010_100}, {3'd2, 8'd0, 6'b100_100},
             {3'd3, 8'd4, 6'b100_001}, {3'd4, 8'd1, 6'b100_010}, {3'd5, 8'd0, 6'b100_100},
             {3'd0, 8'd4, 6'b001_100}};
      do_reset;
      go_to(2);
      checks++;
      if (tick !== 1'b0) begin errors++; $display("FAIL tick_k2 got %b exp 0", tick); end
      go_to(3);
      checks++;
      if (tick !== 1'b1) begin errors++; $display("FAIL tick_k3 got %b exp 1", tick); end
      go_to(4);
      checks++;
      if ({tick, remain} !== {1'b0, 8'd3}) begin errors++; $display("FAIL tick_k4 got tick=%b rem=%0d exp tick=0 rem=3", tick, remain); end
      for (int i = 0; i < 7; i++) begin
         go_to(ks[i]);
         checks++;
         if ({phase, remain, light_ns, light_ew} !== ex[i]) begin
            errors++;
            $display("FAIL run_k%0d got ph=%0d rem=%0d ns=%b ew=%b exp ph=%0d rem=%0d ns=%b ew=%b",
                     ks[i], phase, remain, light_ns, light_ew, ex[i][16:14], ex[i][13:6], ex[i][5:3], ex[i][2:0]);
         end
      end
   endtask

   task automatic test_ped_cut;
      do_reset;
      pulse_req;
      go_to(4);
      checks++;
      if ({phase, remain} !== {3'd0, 8'd1}) begin errors++; $display("FAIL cut_load got ph=%0d rem=%0d exp ph=0 rem=1", phase, remain); end
      go_to(11);
      checks++;
      if ({phase, remain} !== {3'd0, 8'd0}) begin errors++; $display("FAIL cut_k11 got ph=%0d rem=%0d exp ph=0 rem=0", phase, remain); end
      go_to(12);
      checks++;
      if (phase !== 3'd1) begin errors++; $display("FAIL cut_yellow got ph=%0d exp 1", phase); end
      go_to(20);
      checks++;
      if ({phase, ped_ack} !== {3'd2, 1'b1}) begin errors++; $display("FAIL cut_ack got ph=%0d ack=%b exp ph=2 ack=1", phase, ped_ack); end
      go_to(21);
      checks++;
      if (ped_ack !== 1'b0) begin errors++; $display("FAIL cut_ack_len got ack=%b exp 0", ped_ack); end
      go_to(43);
      checks++;
      if (phase !== 3'd3) begin errors++; $display("FAIL cut_ew_full got ph=%0d exp 3", phase); end
      go_to(52);
      checks++;
      if ({phase, ped_ack} !== {3'd5, 1'b0}) begin errors++; $display("FAIL cut_no_reack got ph=%0d ack=%b exp ph=5 ack=0", phase, ped_ack); end
   endtask

   task automatic test_late;
      do_reset;
      go_to(16);
      pulse_req;
      go_to(19);
      checks++;
      if ({phase, remain} !== {3'd0, 8'd0}) begin errors++; $display("FAIL late_k19 got ph=%0d rem=%0d exp ph=0 rem=0", phase, remain); end
      go_to(20);
      checks++;
      if ({phase, remain} !== {3'd1, 8'd1}) begin errors++; $display("FAIL late_k20 got ph=%0d rem=%0d exp ph=1 rem=1", phase, remain); end
      go_to(28);
      checks++;
      if ({phase, ped_ack} !== {3'd2, 1'b1}) begin errors++; $display("FAIL late_ack got ph=%0d ack=%b exp ph=2 ack=1", phase, ped_ack); end
      go_to(54);
      pulse_req;
      go_to(60);
      checks++;
      if ({phase, ped_ack} !== {3'd5, 1'b1}) begin errors++; $display("FAIL yellow_req_ack got ph=%0d ack=%b exp ph=5 ack=1", phase, ped_ack); end
      go_to(64);
      checks++;
      if ({phase, remain} !== {3'd0, 8'd4}) begin errors++; $display("FAIL yellow_req_wrap got ph=%0d rem=%0d exp ph=0 rem=4", phase, remain); end
   endtask

   task automatic test_freeze;
      logic [5:0] exp_l;
      logic       exp_t;
      do_reset;
      go_to(41);
      en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cyc(1);
`ifdef TLC_FLASH_EN
         exp_l = k < 44 ? 6'b100_001 : k < 48 ? 6'b010_010 : 6'b000_000;
         exp_t = (k % 4) == 3;
`else
         exp_l = 6'b100_001;
         exp_t = 1'b0;
`endif
         checks++;
         if ({tick, phase, remain, light_ns, light_ew} !== {exp_t, 3'd3, 8'd2, exp_l}) begin
            errors++;
            $display("FAIL freeze_k%0d got tick=%b ph=%0d rem=%0d ns=%b ew=%b exp tick=%b ph=3 rem=2 lights=%b",
                     k, tick, phase, remain, light_ns, light_ew, exp_t, exp_l);
         end
      end
      en = 1'b1;
`ifdef TLC_FLASH_EN
      go_to(52);
      checks++;
      if ({phase, remain, light_ns, light_ew} !== {3'd3, 8'd1, 6'b100_001}) begin
         errors++; $display("FAIL resume_k52 got ph=%0d rem=%0d ns=%b ew=%b exp ph=3 rem=1 ns=100 ew=001", phase, remain, light_ns, light_ew);
      end
      go_to(59);
      checks++;
      if (phase !== 3'd3) begin errors++; $display("FAIL resume_hold got ph=%0d exp 3", phase); end
      go_to(60);
      checks++;
      if (phase !== 3'd4) begin errors++; $display("FAIL resume_adv got ph=%0d exp 4", phase); end
`else
      go_to(53);
      checks++;
      if ({phase, remain} !== {3'd3, 8'd2}) begin errors++; $display("FAIL resume_k53 got ph=%0d rem=%0d exp ph=3 rem=2", phase, remain); end
      go_to(54);
      checks++;
      if (remain !== 8'd1) begin errors++; $display("FAIL resume_k54 got rem=%0d exp 1", remain); end
      go_to(61);
      checks++;
      if ({phase, remain} !== {3'd3, 8'd0}) begin errors++; $display("FAIL resume_hold got ph=%0d rem=%0d exp ph=3 rem=0", phase, remain); end
      go_to(62);
      checks++;
      if ({phase, light_ns, light_ew} !== {3'd4, 6'b100_010}) begin errors++; $display("FAIL resume_adv got ph=%0d ns=%b ew=%b exp ph=4 ns=100 ew=010", phase, light_ns, light_ew); end
`endif
   endtask

   task automatic test_reset_mid;
      do_reset;
      go_to(53);
      pulse_req;
      go_to(55);
      rst = 1'b0;
      cyc(1);
      rst = 1'b1; k = 0;
      checks++;
      if ({phase, remain, light_ns, light_ew, tick, ped_ack} !== {3'd0, 8'd4, 6'b001_100, 2'b00}) begin
         errors++;
         $display("FAIL midreset_state got ph=%0d rem=%0d ns=%b ew=%b tick=%b ack=%b exp ph=0 rem=4 ns=001 ew=100 tick=0 ack=0",
                  phase, remain, light_ns, light_ew, tick, ped_ack);
      end
      go_to(2);
      checks++;
      if (tick !== 1'b0) begin errors++; $display("FAIL midreset_presc_k2 got tick=%b exp 0", tick); end
      go_to(3);
      checks++;
      if (tick !== 1'b1) begin errors++; $display("FAIL midreset_presc_k3 got tick=%b exp 1", tick); end
      go_to(4);
      checks++;
      if (remain !== 8'd3) begin errors++; $display("FAIL midreset_no_cut got rem=%0d exp 3", remain); end
      go_to(28);
      checks++;
      if ({phase, ped_ack} !== {3'd2, 1'b0}) begin errors++; $display("FAIL midreset_no_ack got ph=%0d ack=%b exp ph=2 ack=0", phase, ped_ack); end
   endtask

   task automatic test_simul;
      do_reset;
      pulse_req;
      go_to(20);
      checks++;
      if (ped_ack !== 1'b1) begin errors++; $display("FAIL simul_ack got ack=%b exp 1", ped_ack); end
      pulse_req;
      checks++;
      if (ped_ack !== 1'b0) begin errors++; $display("FAIL simul_ack_len got ack=%b exp 0", ped_ack); end
      go_to(43);
      checks++;
      if (phase !== 3'd3) begin errors++; $display("FAIL simul_no_cut got ph=%0d exp 3", phase); end
      go_to(52);
      checks++;
      if ({phase, ped_ack} !== {3'd5, 1'b0}) begin errors++; $display("FAIL simul_lost got ph=%0d ack=%b exp ph=5 ack=0", phase, ped_ack); end
   endtask

   initial begin
      test_reset;
      test_run;
      test_ped_cut;
      test_late;
      test_freeze;
      test_reset_mid;
      test_simul;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
